// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle ALU with valid/ready handshakes on both sides.
//             Single-cycle ADD/AND/NOT/XOR, iterative shifts at 1 bit per
//             cycle, iterative shift-add multiply, registered NZP/C/V flags.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [2:0]         op,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               zero,
    output logic               positive,
    output logic               negative,
    output logic               carry,
    output logic               overflow
);

    localparam logic [2:0] c_op_add   = 3'b000;
    localparam logic [2:0] c_op_and   = 3'b001;
    localparam logic [2:0] c_op_not   = 3'b010;
    localparam logic [2:0] c_op_xor   = 3'b011;
    localparam logic [2:0] c_op_lshf  = 3'b100;
    localparam logic [2:0] c_op_rshfl = 3'b101;
    localparam logic [2:0] c_op_rshfa = 3'b110;
    localparam logic [2:0] c_op_mul   = 3'b111;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Counter holds "remaining steps minus one", so the last step is count==0.
    localparam logic [SHIFT_W-1:0] c_mul_count = SHIFT_W'(WIDTH - 1);
    localparam logic [SHIFT_W-1:0] c_one       = SHIFT_W'(1);

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [SHIFT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_a;        // shift working register
    logic               r_sign;     // sign of in1 latched for RSHFA fill
    logic [WIDTH-1:0]   r_b;        // multiplier, consumed LSB first
    logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] r_acc;      // product accumulator

    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_load;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic               w_sh_out;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign w_accept  = in_valid & in_ready;

    // Datapath step values: single-cycle ops from live inputs, iterative ops from working regs.
    always_comb begin
        w_add     = {1'b0, in1} + {1'b0, in2};
        w_acc_nxt = r_acc + (r_b[0] ? r_mcand : '0);
        w_sh_nxt  = r_a;
        w_sh_out  = 1'b0;
        case (r_op)
            c_op_lshf: begin
                w_sh_nxt = {r_a[WIDTH-2:0], 1'b0};
                w_sh_out = r_a[WIDTH-1];
            end
            c_op_rshfl: begin
                w_sh_nxt = {1'b0, r_a[WIDTH-1:1]};
                w_sh_out = r_a[0];
            end
            c_op_rshfa: begin
                w_sh_nxt = {r_sign, r_a[WIDTH-1:1]};
                w_sh_out = r_a[0];
            end
            default: begin
                w_sh_nxt = r_a;
                w_sh_out = 1'b0;
            end
        endcase
    end

    // Next-state logic and the result/flag values loaded on entry to DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res       = out;
        w_c         = 1'b0;
        w_v         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_done;
                    w_load      = 1'b1;
                    case (op)
                        c_op_add: begin
                            w_res = w_add[WIDTH-1:0];
                            w_c   = w_add[WIDTH];
                            w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                                    (w_add[WIDTH-1] != in1[WIDTH-1]);
                        end
                        c_op_and: w_res = in1 & in2;
                        c_op_not: w_res = ~in1;
                        c_op_xor: w_res = in1 ^ in2;
                        c_op_mul: begin
                            w_state_nxt = c_st_busy;
                            w_load      = 1'b0;
                        end
                        default: begin
                            // Shifts: zero amount completes immediately with in1.
                            if (shift == '0) begin
                                w_res = in1;
                            end else begin
                                w_state_nxt = c_st_busy;
                                w_load      = 1'b0;
                            end
                        end
                    endcase
                end
            end
            c_st_busy: begin
                if (r_count == '0) begin
                    w_state_nxt = c_st_done;
                    w_load      = 1'b1;
                    if (r_op == c_op_mul) begin
                        w_res = w_acc_nxt[WIDTH-1:0];
                        w_v   = |w_acc_nxt[2*WIDTH-1:WIDTH];
                    end else begin
                        w_res = w_sh_nxt;
                        w_c   = w_sh_out;
                    end
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // State, operand latches, iterative working registers and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_op     <= c_op_add;
            r_count  <= '0;
            r_a      <= '0;
            r_sign   <= 1'b0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            out      <= '0;
            zero     <= 1'b0;
            positive <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                out      <= w_res;
                zero     <= (w_res == '0);
                negative <= w_res[WIDTH-1];
                positive <= ~w_res[WIDTH-1] & (w_res != '0);
                carry    <= w_c;
                overflow <= w_v;
            end
            if (w_accept) begin
                r_op    <= op;
                r_a     <= in1;
                r_sign  <= in1[WIDTH-1];
                r_b     <= in2;
                r_mcand <= {{WIDTH{1'b0}}, in1};
                r_acc   <= '0;
                r_count <= (op == c_op_mul) ? c_mul_count : (shift - c_one);
            end else if (r_state == c_st_busy) begin
                r_a     <= w_sh_nxt;
                r_acc   <= w_acc_nxt;
                r_mcand <= r_mcand << 1;
                r_b     <= r_b >> 1;
                if (r_count != '0) begin
                    r_count <= r_count - c_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed and streamed self-checking bench for alu_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  op;
    logic [3:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zero;
    logic        positive;
    logic        negative;
    logic        carry;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(16), .SHIFT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .positive(positive), .negative(negative),
        .carry(carry), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector {Z,P,N,C,V}
    function automatic logic [4:0] flags_now();
        return {zero, positive, negative, carry, overflow};
    endfunction

    // Reference model: result plus {C,V}
    function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] s, output logic [15:0] r, output logic c,
                                  output logic v);
        logic [16:0] sum;
        logic [31:0] p;
        int          idx;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (o)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[15:0];
                c   = sum[16];
                v   = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: r = a & b;
            3'd2: r = ~a;
            3'd3: r = a ^ b;
            3'd4: begin
                r = a << s;
                idx = 16 - int'(s);
                if (s != 0) c = a[idx];
            end
            3'd5: begin
                r = a >> s;
                idx = int'(s) - 1;
                if (s != 0) c = a[idx];
            end
            3'd6: begin
                r = $signed(a) >>> s;
                idx = int'(s) - 1;
                if (s != 0) c = a[idx];
            end
            default: begin
                p = {16'b0, a} * {16'b0, b};
                r = p[15:0];
                v = |p[31:16];
            end
        endcase
    endfunction

    // Issue one op from a negedge; returns at the first negedge with out_valid high.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, output int lat);
        op = o; in1 = a; in2 = b; shift = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = ~o; in1 = ~a; in2 = ~b; shift = ~s;
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; op = '0; shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h exp=0000", out); end
        checks++; if (flags_now() !== 5'b00000) begin failures++; $display("FAIL reset_flags got=%b exp=00000", flags_now()); end
    endtask

    task automatic test_add();
        int lat;
        run_op(3'd0, 16'h7FFF, 16'h0001, 4'd0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL add_ovf_latency got=%0d exp=1", lat); end
        checks++; if (out !== 16'h8000) begin failures++; $display("FAIL add_ovf_out got=%h exp=8000", out); end
        checks++; if (flags_now() !== 5'b00101) begin failures++; $display("FAIL add_ovf_flags got=%b exp=00101", flags_now()); end
        take();
        run_op(3'd0, 16'hFFFF, 16'h0001, 4'd0, lat);
        checks++; if (out !== 16'h0000 || flags_now() !== 5'b10010) begin
            failures++; $display("FAIL add_carry got=%h/%b exp=0000/10010", out, flags_now()); end
        take();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'd1, 16'hF0F0, 16'h3C3C, 4'd0, lat);
        checks++; if (out !== 16'h3030 || lat != 1) begin failures++; $display("FAIL and got=%h lat=%0d exp=3030 lat=1", out, lat); end
        take();
        run_op(3'd2, 16'h00FF, 16'h1234, 4'd0, lat);
        checks++; if (out !== 16'hFF00 || flags_now() !== 5'b00100) begin
            failures++; $display("FAIL not got=%h/%b exp=ff00/00100", out, flags_now()); end
        take();
    endtask

    task automatic test_shifts();
        int lat;
        run_op(3'd6, 16'h8000, 16'h0000, 4'd15, lat);
        checks++; if (lat != 16) begin failures++; $display("FAIL rshfa_latency got=%0d exp=16", lat); end
        checks++; if (out !== 16'hFFFF || flags_now() !== 5'b00100) begin
            failures++; $display("FAIL rshfa got=%h/%b exp=ffff/00100", out, flags_now()); end
        take();
        run_op(3'd4, 16'h8001, 16'h0000, 4'd1, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL lshf1_latency got=%0d exp=2", lat); end
        checks++; if (out !== 16'h0002 || flags_now() !== 5'b01010) begin
            failures++; $display("FAIL lshf1 got=%h/%b exp=0002/01010", out, flags_now()); end
        take();
        run_op(3'd4, 16'h1234, 16'h0000, 4'd0, lat);
        checks++; if (lat != 1 || out !== 16'h1234 || carry !== 1'b0) begin
            failures++; $display("FAIL lshf0 got=%h c=%b lat=%0d exp=1234 c=0 lat=1", out, carry, lat); end
        take();
        run_op(3'd5, 16'h0008, 16'h0000, 4'd4, lat);
        checks++; if (lat != 5 || out !== 16'h0000 || flags_now() !== 5'b10010) begin
            failures++; $display("FAIL rshfl got=%h/%b lat=%0d exp=0000/10010 lat=5", out, flags_now(), lat); end
        take();
    endtask

    task automatic test_mul();
        int lat;
        run_op(3'd7, 16'h0100, 16'h0100, 4'd0, lat);
        checks++; if (lat != 17) begin failures++; $display("FAIL mul_latency got=%0d exp=17", lat); end
        checks++; if (out !== 16'h0000 || flags_now() !== 5'b10001) begin
            failures++; $display("FAIL mul_big got=%h/%b exp=0000/10001", out, flags_now()); end
        take();
        run_op(3'd7, 16'h0003, 16'h0005, 4'd0, lat);
        checks++; if (out !== 16'h000F || flags_now() !== 5'b01000) begin
            failures++; $display("FAIL mul_small got=%h/%b exp=000f/01000", out, flags_now()); end
        take();
        run_op(3'd7, 16'hFFFF, 16'hFFFF, 4'd0, lat);
        checks++; if (out !== 16'h0001 || flags_now() !== 5'b01001) begin
            failures++; $display("FAIL mul_ffff got=%h/%b exp=0001/01001", out, flags_now()); end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(3'd0, 16'h0001, 16'h0002, 4'd0, lat);
        op = 3'd0; in1 = 16'h0010; in2 = 16'h0020; shift = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 16'h0003 || flags_now() !== 5'b01000) begin
                failures++; $display("FAIL hold_cycle%0d got v=%b r=%b out=%h fl=%b exp v=1 r=0 out=0003 fl=01000",
                                     i, out_valid, in_ready, out, flags_now()); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0003) begin
            failures++; $display("FAIL after_handshake got v=%b r=%b out=%h exp v=0 r=1 out=0003", out_valid, in_ready, out); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out !== 16'h0030) begin
            failures++; $display("FAIL held_request got v=%b out=%h exp v=1 out=0030", out_valid, out); end
        take();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        op = 3'd7; in1 = 16'h0003; in2 = 16'h0005; shift = 4'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mul_busy got v=%b r=%b exp v=0 r=0", out_valid, in_ready); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0000) begin
            failures++; $display("FAIL mid_reset got v=%b r=%b out=%h exp v=0 r=1 out=0000", out_valid, in_ready, out); end
        run_op(3'd3, 16'hAAAA, 16'hFFFF, 4'd0, lat);
        checks++; if (out !== 16'h5555 || lat != 1) begin
            failures++; $display("FAIL xor_after_reset got=%h lat=%0d exp=5555 lat=1", out, lat); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [20:0] q[$];
        logic [20:0] exp_v;
        logic [20:0] act_v;
        logic [15:0] r;
        logic        c;
        logic        v;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        while (got < 20 && cyc < 3000) begin
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            in1       = 16'($urandom);
            in2       = 16'($urandom);
            shift     = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                act_v = {out, carry, overflow, zero, negative, positive};
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stream_extra got=%h exp=none", act_v);
                end else begin
                    exp_v = q.pop_front();
                    if (act_v !== exp_v) begin
                        failures++; $display("FAIL stream_result%0d got=%h exp=%h", got, act_v, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                model(op, in1, in2, shift, r, c, v);
                q.push_back({r, c, v, (r == 16'h0), r[15], (!r[15] && r != 16'h0)});
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (got != 20 || sent != 20 || q.size() != 0) begin
            failures++; $display("FAIL stream_count got=%0d sent=%0d pending=%0d exp 20/20/0", got, sent, q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_shifts();
        test_mul();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
